dpad_conditioner: RTL and testbench

Conditions D-PAD direction bits for the core input mux. It sits directly downstream of the analog-stick-to-DPAD stage. The block debounces the analog-derived directions on a slow sample tick and ORs them with the controller's digital D-PAD. It then resolves simultaneous opposite directions (SOCD) and registers a clean 4-bit D-PAD, plus a change strobe, for the game input mapping.

---
 rtl/dpad_conditioner_if.sv | 22 ++
 rtl/dpad_conditioner.sv | 134 +++++++++++++
 tb/tb_dpad_conditioner.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/dpad_conditioner_if.sv
// D-PAD conditioner bus: raw analog/digital directions in, clean D-PAD and change strobe out.
// Bit order on every vector is {up, down, left, right}.
interface dpad_conditioner_if;
  logic [3:0] ana_dpad;
  logic [3:0] dig_dpad;
  logic [3:0] dpad;
  logic       dpad_changed;

  modport master (
    output ana_dpad,
    output dig_dpad,
    input  dpad,
    input  dpad_changed
  );

  modport slave (
    input  ana_dpad,
    input  dig_dpad,
    output dpad,
    output dpad_changed
  );
endinterface

// File: rtl/dpad_conditioner.sv
// Debounces analog-derived D-PAD bits, merges the digital D-PAD and resolves SOCD conflicts.
// Define SOCD_LAST_WINS_EN for last-input-wins on left/right; otherwise left+right resolves to neutral.
module dpad_conditioner #(
  parameter logic [15:0] CLK_DIV  = 16'd48000,
  parameter logic [3:0]  DEBOUNCE = 4'd4
) (
  input logic             clk_sys,
  input logic             reset_n,
  dpad_conditioner_if.slave bus
);

  localparam logic [15:0] DIV_LAST = (CLK_DIV <= 16'd1) ? 16'd0 : (CLK_DIV - 16'd1);
  localparam logic [4:0]  DEB_TH   = (DEBOUNCE == 4'd0) ? 5'd1 : {1'b0, DEBOUNCE};

  logic [15:0] presc;
  logic        tick;
  logic [3:0]  deb;
  logic [3:0]  cnt [4];
  logic [3:0]  merged;
  logic [3:0]  resolved;

  assign tick = (presc == DIV_LAST);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  // Equality is tested before the threshold, so an input that returns on the
  // threshold tick clears its count instead of toggling deb.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      deb <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else if (tick) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.ana_dpad[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (({1'b0, cnt[i]} + 5'd1) >= DEB_TH) begin
          deb[i] <= ~deb[i];
          cnt[i] <= '0;
        end else if (cnt[i] != 4'hF) begin
          cnt[i] <= cnt[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      merged <= '0;
    end else begin
      merged <= deb | bus.dig_dpad;
    end
  end

`ifdef SOCD_LAST_WINS_EN
  typedef enum logic [1:0] {
    LR_NONE  = 2'd0,
    LR_LEFT  = 2'd1,
    LR_RIGHT = 2'd2
  } lr_state_t;

  lr_state_t  lr_last;
  lr_state_t  lr_next;
  logic [3:0] merged_prev;
  logic       left_rise;
  logic       right_rise;

  assign left_rise  = merged[1] & ~merged_prev[1];
  assign right_rise = merged[0] & ~merged_prev[0];

  // The winner is taken from this cycle's edges so a newly pressed direction
  // takes effect with the same latency as any other input change.
  always_comb begin
    lr_next = lr_last;
    if (left_rise && right_rise) begin
      lr_next = LR_NONE;
    end else if (left_rise) begin
      lr_next = LR_LEFT;
    end else if (right_rise) begin
      lr_next = LR_RIGHT;
    end else if (!merged[1] && !merged[0]) begin
      lr_next = LR_NONE;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      lr_last     <= LR_NONE;
      merged_prev <= '0;
    end else begin
      lr_last     <= lr_next;
      merged_prev <= merged;
    end
  end
`endif

  always_comb begin
    resolved = merged;
    if (merged[3] && merged[2]) begin
      resolved[3:2] = 2'b00;
    end
    if (merged[1] && merged[0]) begin
`ifdef SOCD_LAST_WINS_EN
      case (lr_next)
        LR_LEFT:  resolved[1:0] = 2'b10;
        LR_RIGHT: resolved[1:0] = 2'b01;
        default:  resolved[1:0] = 2'b00;
      endcase
`else
      resolved[1:0] = 2'b00;
`endif
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      bus.dpad         <= '0;
      bus.dpad_changed <= 1'b0;
    end else begin
      bus.dpad         <= resolved;
      bus.dpad_changed <= (resolved != bus.dpad);
    end
  end

endmodule

// File: tb/tb_dpad_conditioner.sv
// Directed bench for dpad_conditioner with CLK_DIV=4, DEBOUNCE=2.
// Ticks are sampled on every 4th rising edge after reset release.
module tb_dpad_conditioner;

`ifdef SOCD_LAST_WINS_EN
  localparam bit LAST_WINS = 1'b1;
`else
  localparam bit LAST_WINS = 1'b0;
`endif

  logic clk_sys = 1'b0;
  logic reset_n = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   edges = 0;

  dpad_conditioner_if bus ();

  dpad_conditioner #(
    .CLK_DIV  (16'd4),
    .DEBOUNCE (4'd2)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic step_to(input int target);
    while (edges < target) begin
      @(posedge clk_sys);
      #1;
      edges++;
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] ana, input logic [3:0] dig);
    bus.ana_dpad = ana;
    bus.dig_dpad = dig;
  endtask

  task automatic check_output(input string tag, input logic [3:0] exp_dpad, input logic exp_changed);
    vectors++;
    assert (bus.dpad === exp_dpad) else begin
      miscompares++;
      $error("[TB] FAIL %s dpad: observed %b expected %b", tag, bus.dpad, exp_dpad);
    end
    vectors++;
    assert (bus.dpad_changed === exp_changed) else begin
      miscompares++;
      $error("[TB] FAIL %s dpad_changed: observed %b expected %b", tag, bus.dpad_changed, exp_changed);
    end
  endtask

  initial begin
    apply_stimulus(4'b0000, 4'b0000);
    #2 reset_n = 1'b0;
    #1 check_output("in_reset", 4'b0000, 1'b0);
    @(posedge clk_sys);
    @(posedge clk_sys);
    #1 reset_n = 1'b1;
    edges = 0;
    check_output("reset_release", 4'b0000, 1'b0);
    for (int i = 1; i <= 100; i++) begin
      step_to(i);
      check_output("idle_after_reset", 4'b0000, 1'b0);
    end

    // Digital path: two cycles to dpad, one-cycle strobe each way
    apply_stimulus(4'b0000, 4'b0001);
    step_to(101); check_output("dig_lat_n1", 4'b0000, 1'b0);
    step_to(102); check_output("dig_lat_n2", 4'b0001, 1'b1);
    step_to(103); check_output("dig_lat_n3", 4'b0001, 1'b0);
    apply_stimulus(4'b0000, 4'b0000);
    step_to(104); check_output("dig_rel_n1", 4'b0001, 1'b0);
    step_to(105); check_output("dig_rel_n2", 4'b0000, 1'b1);
    step_to(106); check_output("dig_rel_n3", 4'b0000, 1'b0);

    // Analog glitch seen by a single tick (edge 108) must not propagate
    apply_stimulus(4'b1000, 4'b0000);
    step_to(108);
    apply_stimulus(4'b0000, 4'b0000);
    for (int i = 109; i <= 116; i++) begin
      step_to(i);
      check_output("ana_glitch", 4'b0000, 1'b0);
    end

    // Held through ticks at 120 and 124: deb at 124, dpad at 126
    apply_stimulus(4'b1000, 4'b0000);
    step_to(125); check_output("ana_hold_pre", 4'b0000, 1'b0);
    step_to(126); check_output("ana_hold_on", 4'b1000, 1'b1);
    step_to(127); check_output("ana_hold_steady", 4'b1000, 1'b0);
    apply_stimulus(4'b0000, 4'b0000);
    step_to(133); check_output("ana_rel_pre", 4'b1000, 1'b0);
    step_to(134); check_output("ana_rel_off", 4'b0000, 1'b1);

    // Up/down conflict is always neutral
    apply_stimulus(4'b0000, 4'b1100);
    step_to(136); check_output("socd_ud_both", 4'b0000, 1'b0);
    apply_stimulus(4'b0000, 4'b1000);
    step_to(137); check_output("socd_ud_pre", 4'b0000, 1'b0);
    step_to(138); check_output("socd_ud_up", 4'b1000, 1'b1);
    apply_stimulus(4'b0000, 4'b0000);
    step_to(140); check_output("socd_ud_clear", 4'b0000, 1'b1);

    // Left/right resolution
    apply_stimulus(4'b0000, 4'b0010);
    step_to(142); check_output("lr_left", 4'b0010, 1'b1);
    apply_stimulus(4'b0000, 4'b0011);
    step_to(144); check_output("lr_right_last", LAST_WINS ? 4'b0001 : 4'b0000, 1'b1);
    apply_stimulus(4'b0000, 4'b0010);
    step_to(146); check_output("lr_drop_right", 4'b0010, 1'b1);
    apply_stimulus(4'b0000, 4'b0000);
    step_to(148); check_output("lr_release", 4'b0000, 1'b1);
    apply_stimulus(4'b0000, 4'b0011);
    step_to(150); check_output("lr_both_rise", 4'b0000, 1'b0);
    step_to(152); check_output("lr_both_hold", 4'b0000, 1'b0);
    apply_stimulus(4'b0000, 4'b0000);
    step_to(154); check_output("lr_idle", 4'b0000, 1'b0);
    apply_stimulus(4'b0000, 4'b0001);
    step_to(156); check_output("lr_right", 4'b0001, 1'b1);
    apply_stimulus(4'b0000, 4'b0011);
    step_to(158); check_output("lr_left_last", LAST_WINS ? 4'b0010 : 4'b0000, 1'b1);
    apply_stimulus(4'b0000, 4'b0000);
    step_to(160); check_output("lr_final_release", 4'b0000, LAST_WINS);

    // Reset with cnt=1 pending: full two ticks are needed again afterwards
    apply_stimulus(4'b0100, 4'b0000);
    step_to(164);
    reset_n = 1'b0;
    #1 check_output("mid_reset", 4'b0000, 1'b0);
    @(posedge clk_sys);
    @(posedge clk_sys);
    #1 reset_n = 1'b1;
    edges = 0;
    check_output("mid_reset_release", 4'b0000, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      step_to(i);
      check_output("post_reset_wait", 4'b0000, 1'b0);
    end
    step_to(10); check_output("post_reset_accept", 4'b0100, 1'b1);
    step_to(11); check_output("post_reset_steady", 4'b0100, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
